// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : pipe_pkg
//  Brief   : Shared types and constants for the generic inter-stage register.
//  Rev     : 1.0  initial release
// ============================================================================
package pipe_pkg;

  // Holding state of a stage register: nothing, output only, output + skid
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    MAIN  = 2'd1,
    BOTH  = 2'd2
  } pipe_state_t;

  // Widest control bus supported; users slice the low CTRL_W bits
  localparam int PIPE_CTRL_MAX_W = 1024;

  // Control value carried by a bubble: every control line deasserted
  localparam logic [PIPE_CTRL_MAX_W-1:0] PIPE_BUBBLE_CTRL = '0;

  // Width of the occupancy status (counts 0..2)
  localparam int PIPE_OCC_W = 2;

  // Number of beats held in a given state
  function automatic logic [PIPE_OCC_W-1:0] pipeOccupancy(input pipe_state_t state);
    logic [PIPE_OCC_W-1:0] occ;
    occ = '0;
    case (state)
      EMPTY:   occ = 2'd0;
      MAIN:    occ = 2'd1;
      BOTH:    occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_skid_slot.sv
`default_nettype none
// ============================================================================
//  Module  : pipe_skid_slot
//  Brief   : Single storage entry holding one packed {ctrl, data} beat that
//            arrived while the output register was stalled.
//  Rev     : 1.0  initial release
// ============================================================================
module pipe_skid_slot
  import pipe_pkg::*;
#(
  parameter int WIDTH = 80
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Load,
  input  logic             Clear,
  input  logic [WIDTH-1:0] LoadData,
  output logic [WIDTH-1:0] HeldData
);

  // Entry register: clear wins over load so a flushed beat is never kept
  always_ff @(posedge Clk) begin
    if (Rst || Clear) begin
      HeldData <= '0;
    end else if (Load) begin
      HeldData <= LoadData;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module  : pipe_stage_reg
//  Brief   : Generic valid/ready pipeline stage register with optional
//            two-entry skid buffer, flush-to-bubble and occupancy status.
//            All outputs except the SKID=0 ready come straight from flops.
//  Rev     : 1.0  initial release
// ============================================================================
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 16,
  parameter int SKID   = 1
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Flush,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [DATA_W-1:0]     InData,
  input  logic [CTRL_W-1:0]     InCtrl,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic [DATA_W-1:0]     OutData,
  output logic [CTRL_W-1:0]     OutCtrl,
  output logic [PIPE_OCC_W-1:0] Occupancy
);

  localparam logic [CTRL_W-1:0] C_BUBBLE = PIPE_BUBBLE_CTRL[CTRL_W-1:0];

  pipe_state_t       r_state;
  logic              w_xferIn;
  logic              w_xferOut;
  logic [DATA_W-1:0] w_skidData;
  logic [CTRL_W-1:0] w_skidCtrl;

  // A beat offered during a flush is dropped, so it never counts as accepted
  assign w_xferIn  = InValid && InReady && !Flush;
  assign w_xferOut = OutValid && OutReady;

  generate
    if (SKID != 0) begin : g_skid
      logic                     r_inReady;
      logic                     w_skidLoad;
      logic                     w_skidClear;
      logic [DATA_W+CTRL_W-1:0] w_skidHeld;

      // Second beat arriving while the output register is stalled
      assign w_skidLoad  = (r_state == MAIN) && w_xferIn && !w_xferOut;
      // Skid drains into the output register, or is discarded on flush
      assign w_skidClear = Flush || ((r_state == BOTH) && w_xferOut);

      pipe_skid_slot #(
        .WIDTH (DATA_W + CTRL_W)
      ) u_skidSlot (
        .Clk      (Clk),
        .Rst      (Rst),
        .Load     (w_skidLoad),
        .Clear    (w_skidClear),
        .LoadData ({InCtrl, InData}),
        .HeldData (w_skidHeld)
      );

      assign w_skidData = w_skidHeld[DATA_W-1:0];
      assign w_skidCtrl = w_skidHeld[DATA_W +: CTRL_W];

      // Registered ready: low exactly while the next state holds two beats
      always_ff @(posedge Clk) begin
        if (Rst || Flush) begin
          r_inReady <= 1'b1;
        end else begin
          r_inReady <= !(w_skidLoad || ((r_state == BOTH) && !w_xferOut));
        end
      end

      assign InReady = r_inReady;
    end else begin : g_noSkid
      // Single entry: BOTH is unreachable, so the skid source is never used
      assign w_skidData = '0;
      assign w_skidCtrl = '0;
      assign InReady    = !OutValid || OutReady;
    end
  endgenerate

  // Holding-state machine; owns the output register and status outputs
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state   <= EMPTY;
      OutValid  <= 1'b0;
      OutData   <= '0;
      OutCtrl   <= C_BUBBLE;
      Occupancy <= pipeOccupancy(EMPTY);
    end else if (Flush) begin
      // OutData deliberately keeps its last value; only control is bubbled
      r_state   <= EMPTY;
      OutValid  <= 1'b0;
      OutCtrl   <= C_BUBBLE;
      Occupancy <= pipeOccupancy(EMPTY);
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (w_xferIn) begin
            r_state   <= MAIN;
            OutValid  <= 1'b1;
            OutData   <= InData;
            OutCtrl   <= InCtrl;
            Occupancy <= pipeOccupancy(MAIN);
          end
        end
        MAIN: begin
          if (w_xferIn && w_xferOut) begin
            OutData <= InData;
            OutCtrl <= InCtrl;
          end else if (w_xferIn) begin
            // New beat parks in the skid slot; output register untouched
            r_state   <= BOTH;
            Occupancy <= pipeOccupancy(BOTH);
          end else if (w_xferOut) begin
            r_state   <= EMPTY;
            OutValid  <= 1'b0;
            OutCtrl   <= C_BUBBLE;
            Occupancy <= pipeOccupancy(EMPTY);
          end
        end
        BOTH: begin
          if (w_xferOut) begin
            r_state   <= MAIN;
            OutData   <= w_skidData;
            OutCtrl   <= w_skidCtrl;
            Occupancy <= pipeOccupancy(MAIN);
          end
        end
        default: begin
          r_state   <= EMPTY;
          OutValid  <= 1'b0;
          OutCtrl   <= C_BUBBLE;
          Occupancy <= pipeOccupancy(EMPTY);
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module  : tb_pipe_stage_reg
//  Brief   : Bench for pipe_stage_reg; drives SKID=1 and SKID=0 instances with
//            the same stimulus and compares each against a queue model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_pipe_stage_reg;

  localparam int DW = 64;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          inValid;
  logic          outReady;
  logic [DW-1:0] inData;
  logic [CW-1:0] inCtrl;

  logic          inReady1, outValid1, inReady0, outValid0;
  logic [DW-1:0] outData1, outData0;
  logic [CW-1:0] outCtrl1, outCtrl0;
  logic [1:0]    occ1, occ0;

  // Model: each DUT is a FIFO of held beats, capacity 2 (SKID=1) or 1 (SKID=0)
  logic [DW+CW-1:0] q1[$];
  logic [DW+CW-1:0] q0[$];

  int nChecks = 0;
  int nPass   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) u_dutSkid (
    .Clk(clk), .Rst(rst), .Flush(flush), .InValid(inValid), .InReady(inReady1),
    .InData(inData), .InCtrl(inCtrl), .OutValid(outValid1), .OutReady(outReady),
    .OutData(outData1), .OutCtrl(outCtrl1), .Occupancy(occ1)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) u_dutNoSkid (
    .Clk(clk), .Rst(rst), .Flush(flush), .InValid(inValid), .InReady(inReady0),
    .InData(inData), .InCtrl(inCtrl), .OutValid(outValid0), .OutReady(outReady),
    .OutData(outData0), .OutCtrl(outCtrl0), .Occupancy(occ0)
  );

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic checkDut(input string who, input int sz, input logic [DW+CW-1:0] front,
                          input logic expRdy, input logic gotRdy, input logic gotValid,
                          input logic [DW-1:0] gotData, input logic [CW-1:0] gotCtrl,
                          input logic [1:0] gotOcc);
    checkVal({who, ".InReady"},   64'(gotRdy),   64'(expRdy));
    checkVal({who, ".OutValid"},  64'(gotValid), 64'(sz > 0));
    checkVal({who, ".Occupancy"}, 64'(gotOcc),   64'(sz));
    checkVal({who, ".OutCtrl"},   64'(gotCtrl),  (sz > 0) ? 64'(front[DW +: CW]) : 64'd0);
    if (sz > 0) checkVal({who, ".OutData"}, gotData, front[DW-1:0]);
  endtask

  // One clock: compare at negedge, then advance the model across the posedge
  task automatic tick();
    logic [DW+CW-1:0] f1, f0;
    logic rdy1, rdy0, in1, in0, out1, out0;
    @(negedge clk);
    f1   = (q1.size() > 0) ? q1[0] : '0;
    f0   = (q0.size() > 0) ? q0[0] : '0;
    rdy1 = (q1.size() < 2);
    rdy0 = (q0.size() == 0) || outReady;
    checkDut("skid1", q1.size(), f1, rdy1, inReady1, outValid1, outData1, outCtrl1, occ1);
    checkDut("skid0", q0.size(), f0, rdy0, inReady0, outValid0, outData0, outCtrl0, occ0);
    in1  = inValid && rdy1 && !flush;
    in0  = inValid && rdy0 && !flush;
    out1 = (q1.size() > 0) && outReady;
    out0 = (q0.size() > 0) && outReady;
    @(posedge clk);
    if (rst || flush) begin
      q1.delete();
      q0.delete();
    end else begin
      if (out1) void'(q1.pop_front());
      if (out0) void'(q0.pop_front());
      if (in1) q1.push_back({inCtrl, inData});
      if (in0) q0.push_back({inCtrl, inData});
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c);
    inValid = v;
    inData  = d;
    inCtrl  = c;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; outReady = 1'b1;
    drive(1'b0, '0, '0);
    @(posedge clk); #1;
    tick();
    rst = 1'b0;
    checkVal("reset.OutValid", 64'(outValid1), 64'd0);
    checkVal("reset.InReady",  64'(inReady1),  64'd1);

    // Streaming 1..8 with OutReady held high: each beat visible one edge later
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, DW'(i), CW'(i + 'h100));
      tick();
      checkVal("stream1.data", outData1, 64'(i));
      checkVal("stream0.data", outData0, 64'(i));
      checkVal("stream1.ctrl", 64'(outCtrl1), 64'(i + 'h100));
    end
    drive(1'b0, '0, '0);
    tick(); tick();

    // Stall with skid: A in output, B in skid, C held upstream
    outReady = 1'b0;
    drive(1'b1, DW'('hA), CW'('h1)); tick();
    drive(1'b1, DW'('hB), CW'('h2)); tick();
    drive(1'b1, DW'('hC), CW'('h3)); tick();
    checkVal("stall.data", outData1, 64'hA);
    checkVal("stall.occ",  64'(occ1), 64'd2);
    checkVal("stall.rdy",  64'(inReady1), 64'd0);
    outReady = 1'b1;
    tick();
    checkVal("drain.B", outData1, 64'hB);
    tick();
    checkVal("drain.C", outData1, 64'hC);
    drive(1'b0, '0, '0);
    tick(); tick();

    // Flush while two beats held and a new beat offered
    outReady = 1'b0;
    drive(1'b1, DW'('h11), CW'('h5)); tick();
    drive(1'b1, DW'('h12), CW'('h6)); tick();
    tick();
    flush = 1'b1;
    drive(1'b1, DW'('hD), CW'('h00FF)); tick();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    checkVal("flush.valid", 64'(outValid1), 64'd0);
    checkVal("flush.ctrl",  64'(outCtrl1),  64'd0);
    checkVal("flush.occ",   64'(occ1),      64'd0);
    checkVal("flush.rdy",   64'(inReady1),  64'd1);
    outReady = 1'b1;
    tick(); tick();

    // Single-entry stall: ready follows OutReady in the same cycle
    outReady = 1'b0;
    drive(1'b1, DW'('h21), CW'('h7)); tick();
    checkVal("noskid.stallRdy", 64'(inReady0), 64'd0);
    outReady = 1'b1;
    #1;
    checkVal("noskid.openRdy", 64'(inReady0), 64'd1);
    drive(1'b1, DW'('h22), CW'('h8)); tick();
    checkVal("noskid.replace", outData0, 64'h22);
    drive(1'b1, DW'('h23), CW'('h9)); tick();
    checkVal("noskid.replace2", outData0, 64'h23);

    // Reset asserted for two cycles mid-stall
    outReady = 1'b0;
    drive(1'b1, DW'('h31), CW'('hA)); tick();
    drive(1'b1, DW'('h32), CW'('hB)); tick();
    rst = 1'b1; tick(); tick();
    rst = 1'b0;
    drive(1'b0, '0, '0);
    checkVal("rstmid.valid", 64'(outValid1), 64'd0);
    checkVal("rstmid.ctrl",  64'(outCtrl1),  64'd0);
    checkVal("rstmid.occ",   64'(occ1),      64'd0);
    checkVal("rstmid.rdy",   64'(inReady1),  64'd1);
    tick();

    // Random valid/ready traffic with occasional flush and reset
    for (int n = 0; n < 10000; n++) begin
      rst      = ($urandom_range(0, 499) == 0);
      flush    = ($urandom_range(0, 49) == 0);
      outReady = ($urandom_range(0, 9) < 7);
      drive(($urandom_range(0, 9) < 7), {$urandom, $urandom}, CW'($urandom));
      tick();
    end
    rst = 1'b0; flush = 1'b0;
    drive(1'b0, '0, '0);
    tick();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
`default_nettype wire
